safe_access_controller: RTL and testbench
=========================================

# safe_access_controller

Decision stage of the digital safe, directly downstream of the four-digit entry/display stage. Takes the packed 16-bit entered code when entry completes, compares it with the stored passcode, and tracks failed attempts, with a timed lockout after the last allowed failure. When the safe is open, it can program a new passcode. It also returns a one-cycle clear pulse that restarts digit entry after every decision.

## Interface
- `DEFAULT_CODE`, default 16'h1234: passcode loaded on reset, one BCD digit per nibble, {d3,d2,d1,d0}.
- `MAX_ATTEMPTS`, default 3: consecutive failures that trigger lockout; legal range 1..3.
- `LOCKOUT_CYCLES`, default 500_000_000: lockout duration in clk cycles (10 s at 50 MHz); 32-bit counter.
- `MASTER_CODE`, default 16'h9999: used only when `SAFE_MASTER_CODE_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `sys_reset`  in  1  global reset, synchronous, active-high.
- `code_complete`  in  1  one-cycle pulse; `entered_code` is valid and holds four digits.
- `entered_code`  in  16  {d3,d2,d1,d0} from the entry/display stage.
- `lock_req`  in  1  one-cycle pulse: relock the safe.
- `program_req`  in  1  one-cycle pulse: enter passcode-programming mode.
- `entry_clear`  out  1  one-cycle pulse: restart digit entry upstream.
- `unlocked`  out  1  high in OPEN and PROGRAM.
- `lockout_active`  out  1  high in LOCKOUT.
- `program_mode`  out  1  high in PROGRAM.
- `attempts_left`  out  2  remaining attempts before lockout.
- `success_pulse`  out  1  one cycle: correct code accepted.
- `fail_pulse`  out  1  one cycle: wrong code, or rejected program code.
- `prog_done_pulse`  out  1  one cycle: new passcode stored.

## Operation
- States: LOCKED, CHECK, OPEN, PROGRAM, LOCKOUT.
- Reset values:
  - state LOCKED; stored code = `DEFAULT_CODE`.
  - `attempts_left` = `MAX_ATTEMPTS`; lockout counter 0.
  - All outputs low except `attempts_left`.
- LOCKED:
  - `code_complete` captures `entered_code` into a capture register and moves to CHECK.
  - `lock_req` and `program_req` are ignored.
- CHECK (always exactly one cycle):
  - Match with stored code: go to OPEN; `attempts_left` reloads to `MAX_ATTEMPTS`; pulse `success_pulse` and `entry_clear`.
  - Mismatch with `attempts_left` > 1: decrement, go to LOCKED, pulse `fail_pulse` and `entry_clear`.
  - Mismatch with `attempts_left` = 1: set it to 0, go to LOCKOUT, clear the counter, pulse `fail_pulse` and `entry_clear`.
- OPEN:
  - `lock_req` goes to LOCKED with `entry_clear`.
  - Otherwise `program_req` goes to PROGRAM with `entry_clear`.
  - `lock_req` wins when both pulse together.
  - `code_complete` is ignored.
- PROGRAM:
  - `lock_req` goes to LOCKED; the stored code is unchanged.
  - `code_complete` with every nibble ≤ 9 writes the stored code, returns to OPEN, and pulses `prog_done_pulse` and `entry_clear`.
  - `code_complete` with any nibble > 9 stays in PROGRAM and pulses `fail_pulse` and `entry_clear`; the stored code is unchanged.
  - If `code_complete` and `lock_req` arrive in the same cycle, `lock_req` wins and nothing is written.
- LOCKOUT:
  - Counter increments every cycle.
  - When it reaches `LOCKOUT_CYCLES`-1: go to LOCKED, reload `attempts_left`, pulse `entry_clear`.
  - All other inputs are ignored.
- A `code_complete` that arrives while in CHECK is dropped.
- `sys_reset` in any state, mid-lockout included, restores reset values in the next cycle. The programmed passcode is lost and reverts to `DEFAULT_CODE`.

## Timing
- `code_complete` high in cycle N in LOCKED:
  - state is CHECK in cycle N+1;
  - the new state, new `attempts_left` and all pulses are visible in cycle N+2.
- OPEN/PROGRAM/LOCKOUT transitions take effect, with their pulses, in the cycle after the triggering input.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles; `lockout_active` is high for exactly that many cycles.
- All outputs are registered; no combinational input-to-output path.
- Pulse outputs are never high for two consecutive cycles from the same event.

## Configuration
- `SAFE_MASTER_CODE_EN` defined:
  - In CHECK, a code equal to `MASTER_CODE` is accepted as a match.
  - In LOCKOUT, `code_complete` with `MASTER_CODE` ends lockout immediately: go to OPEN, reload `attempts_left`, pulse `success_pulse` and `entry_clear`, in the cycle after the input.
  - Other `code_complete` inputs in LOCKOUT are still ignored.
- Not defined: `MASTER_CODE` is unused, and no logic for it is synthesised.

## Test plan
- Correct code after reset:
  - Stimulus: reset, then `code_complete` with 16'h1234.
  - Response: `unlocked`=1 two cycles later, `success_pulse`=1 and `entry_clear`=1 for one cycle, `attempts_left`=3.
- Wrong codes into lockout (`LOCKOUT_CYCLES`=20):
  - Stimulus: three `code_complete` with 16'h0000.
  - Response: `attempts_left` goes 2, 1, 0; `lockout_active` high for exactly 20 cycles; then LOCKED with `attempts_left`=3.
- Program then relock:
  - Stimulus: open the safe, `program_req`, `code_complete` with 16'h5678, `lock_req`.
  - Response: 16'h1234 now fails and 16'h5678 succeeds.
- Invalid program code and priority:
  - Stimulus 1: in PROGRAM, `code_complete` with 16'h12A4.
  - Response 1: `fail_pulse`, still in PROGRAM, stored code unchanged.
  - Stimulus 2: in OPEN, `lock_req` and `program_req` in the same cycle.
  - Response 2: LOCKED.
- Reset mid-lockout:
  - Stimulus: assert `sys_reset` 5 cycles into lockout.
  - Response: next cycle LOCKED, `lockout_active`=0, `attempts_left`=3.
- With `SAFE_MASTER_CODE_EN`:
  - Stimulus: `code_complete` with 16'h9999 during LOCKOUT.
  - Response: OPEN next cycle with `success_pulse`.
  - Without the macro, the same stimulus is ignored and LOCKOUT runs its full length.

Source files
------------

// File: rtl/safe_access_controller.sv
// safe_access_controller: passcode check, attempt counting, timed lockout and passcode programming.
// Define SAFE_MASTER_CODE_EN to accept MASTER_CODE as an override in CHECK and LOCKOUT.
module safe_access_controller #(
   parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
   parameter logic [1:0]  MAX_ATTEMPTS   = 2'd3,
   parameter logic [31:0] LOCKOUT_CYCLES = 32'd500_000_000
`ifdef SAFE_MASTER_CODE_EN
   ,parameter logic [15:0] MASTER_CODE   = 16'h9999
`endif
) (
   input  logic        clk,
   input  logic        sys_reset,
   input  logic        code_complete,
   input  logic [15:0] entered_code,
   input  logic        lock_req,
   input  logic        program_req,
   output logic        entry_clear,
   output logic        unlocked,
   output logic        lockout_active,
   output logic        program_mode,
   output logic [1:0]  attempts_left,
   output logic        success_pulse,
   output logic        fail_pulse,
   output logic        prog_done_pulse
);
   typedef enum logic [2:0] {LOCKED, CHECK, OPEN, PROGRAM, LOCKOUT} state_t;
   state_t state, state_nxt;
   logic [15:0] code, code_nxt, cap, cap_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [1:0] attempts_nxt;
   logic clear_nxt, success_nxt, fail_nxt, done_nxt;
   logic match, valid, master_unlock;
   assign valid = entered_code[15:12] <= 4'd9 && entered_code[11:8] <= 4'd9 &&
                  entered_code[7:4] <= 4'd9 && entered_code[3:0] <= 4'd9;
`ifdef SAFE_MASTER_CODE_EN
   assign match = cap == code || cap == MASTER_CODE;
   assign master_unlock = code_complete && entered_code == MASTER_CODE;
`else
   assign match = cap == code;
   assign master_unlock = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      code_nxt = code;
      cap_nxt = cap;
      cnt_nxt = cnt;
      attempts_nxt = attempts_left;
      clear_nxt = 1'b0;
      success_nxt = 1'b0;
      fail_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state)
         LOCKED: if (code_complete) begin
            cap_nxt = entered_code;
            state_nxt = CHECK;
         end
         CHECK: begin
            clear_nxt = 1'b1;
            success_nxt = match;
            fail_nxt = !match;
            if (match) begin
               state_nxt = OPEN;
               attempts_nxt = MAX_ATTEMPTS;
            end else if (attempts_left > 2'd1) begin
               state_nxt = LOCKED;
               attempts_nxt = attempts_left - 2'd1;
            end else begin
               state_nxt = LOCKOUT;
               attempts_nxt = 2'd0;
               cnt_nxt = 32'd0;
            end
         end
         OPEN: if (lock_req || program_req) begin
            state_nxt = lock_req ? LOCKED : PROGRAM;
            clear_nxt = 1'b1;
         end
         PROGRAM: if (lock_req) begin
            state_nxt = LOCKED;
            clear_nxt = 1'b1;
         end else if (code_complete) begin
            clear_nxt = 1'b1;
            fail_nxt = !valid;
            done_nxt = valid;
            if (valid) begin
               code_nxt = entered_code;
               state_nxt = OPEN;
            end
         end
         LOCKOUT: if (master_unlock) begin
            state_nxt = OPEN;
            attempts_nxt = MAX_ATTEMPTS;
            success_nxt = 1'b1;
            clear_nxt = 1'b1;
         end else if (cnt == LOCKOUT_CYCLES - 32'd1) begin
            state_nxt = LOCKED;
            attempts_nxt = MAX_ATTEMPTS;
            clear_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt + 32'd1;
         end
         default: state_nxt = LOCKED;
      endcase
   end
   // Level outputs are decoded from the next state so they stay aligned with the registered state.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         state <= LOCKED;
         code <= DEFAULT_CODE;
         cap <= 16'd0;
         cnt <= 32'd0;
         attempts_left <= MAX_ATTEMPTS;
         entry_clear <= 1'b0;
         unlocked <= 1'b0;
         lockout_active <= 1'b0;
         program_mode <= 1'b0;
         success_pulse <= 1'b0;
         fail_pulse <= 1'b0;
         prog_done_pulse <= 1'b0;
      end else begin
         state <= state_nxt;
         code <= code_nxt;
         cap <= cap_nxt;
         cnt <= cnt_nxt;
         attempts_left <= attempts_nxt;
         entry_clear <= clear_nxt;
         unlocked <= state_nxt == OPEN || state_nxt == PROGRAM;
         lockout_active <= state_nxt == LOCKOUT;
         program_mode <= state_nxt == PROGRAM;
         success_pulse <= success_nxt;
         fail_pulse <= fail_nxt;
         prog_done_pulse <= done_nxt;
      end
   end
endmodule

// File: tb/tb_safe_access_controller.sv
// tb_safe_access_controller: directed and randomized checks against a transaction-level model of the safe.
module tb_safe_access_controller;
   localparam int LOCK_LEN = 20;
   localparam int M_LOCKED = 0, M_OPEN = 1, M_PROG = 2, M_LOCKOUT = 3;
`ifdef SAFE_MASTER_CODE_EN
   localparam bit MASTER_EN = 1'b1;
`else
   localparam bit MASTER_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic sys_reset, code_complete, lock_req, program_req;
   logic [15:0] entered_code;
   logic entry_clear, unlocked, lockout_active, program_mode;
   logic [1:0] attempts_left;
   logic success_pulse, fail_pulse, prog_done_pulse;
   int checks = 0, passed = 0;
   logic [15:0] m_code;
   int m_att, m_st;
   always #5 clk = ~clk;
   safe_access_controller #(.LOCKOUT_CYCLES(32'd20)) dut (
      .clk(clk), .sys_reset(sys_reset), .code_complete(code_complete),
      .entered_code(entered_code), .lock_req(lock_req), .program_req(program_req),
      .entry_clear(entry_clear), .unlocked(unlocked), .lockout_active(lockout_active),
      .program_mode(program_mode), .attempts_left(attempts_left),
      .success_pulse(success_pulse), .fail_pulse(fail_pulse), .prog_done_pulse(prog_done_pulse)
   );
   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   task automatic check_levels(input string tag);
      check({tag, ".unlocked"}, unlocked, m_st == M_OPEN || m_st == M_PROG);
      check({tag, ".program_mode"}, program_mode, m_st == M_PROG);
      check({tag, ".lockout"}, lockout_active, m_st == M_LOCKOUT);
      check({tag, ".attempts"}, attempts_left, m_att);
   endtask
   task automatic check_quiet(input string tag);
      check({tag, ".quiet"}, {entry_clear, success_pulse, fail_pulse, prog_done_pulse}, 0);
   endtask
   function automatic bit is_bcd(input logic [15:0] c);
      for (int i = 0; i < 4; i++) if ((int'(c) >> (4 * i)) % 16 > 9) return 1'b0;
      return 1'b1;
   endfunction
   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction
   task automatic try_code(input logic [15:0] c, input string tag);
      bit ok;
      code_complete = 1'b1;
      entered_code = c;
      tick();
      code_complete = 1'b0;
      check_quiet({tag, ".check_cycle"});
      check_levels({tag, ".check_cycle"});
      tick();
      ok = c == m_code || (MASTER_EN && c == 16'h9999);
      if (ok) begin
         m_st = M_OPEN;
         m_att = 3;
      end else if (m_att > 1) m_att--;
      else begin
         m_att = 0;
         m_st = M_LOCKOUT;
      end
      check({tag, ".success"}, success_pulse, ok);
      check({tag, ".fail"}, fail_pulse, !ok);
      check({tag, ".clear"}, entry_clear, 1);
      check_levels(tag);
      if (m_st != M_LOCKOUT) begin
         tick();
         check_quiet({tag, ".after"});
      end
   endtask
   task automatic wait_lockout(input int start, input string tag);
      int n = start;
      while (lockout_active === 1'b1 && n < 1000) begin
         n++;
         tick();
      end
      check({tag, ".length"}, n, LOCK_LEN);
      m_st = M_LOCKED;
      m_att = 3;
      check({tag, ".clear"}, entry_clear, 1);
      check_levels({tag, ".end"});
   endtask
   task automatic pulse_req(input bit l, input bit p, input string tag);
      bit exp_clear = 1'b0, chk_clear = 1'b1;
      lock_req = l;
      program_req = p;
      tick();
      lock_req = 1'b0;
      program_req = 1'b0;
      if (m_st == M_OPEN && (l || p)) begin
         m_st = l ? M_LOCKED : M_PROG;
         exp_clear = 1'b1;
      end else if (m_st == M_PROG && l) begin
         m_st = M_LOCKED;
         chk_clear = 1'b0;
      end
      if (chk_clear) check({tag, ".clear"}, entry_clear, exp_clear);
      check_levels(tag);
   endtask
   task automatic prog_code(input logic [15:0] c, input string tag);
      bit ok = is_bcd(c);
      code_complete = 1'b1;
      entered_code = c;
      tick();
      code_complete = 1'b0;
      if (ok) begin
         m_code = c;
         m_st = M_OPEN;
      end
      check({tag, ".done"}, prog_done_pulse, ok);
      check({tag, ".fail"}, fail_pulse, !ok);
      check({tag, ".clear"}, entry_clear, 1);
      check_levels(tag);
      tick();
      check_quiet({tag, ".after"});
   endtask
   task automatic ignored_code(input logic [15:0] c, input string tag);
      code_complete = 1'b1;
      entered_code = c;
      tick();
      code_complete = 1'b0;
      check_quiet(tag);
      check_levels(tag);
   endtask
   initial begin
      logic [15:0] bad;
      sys_reset = 1'b1;
      code_complete = 1'b0;
      lock_req = 1'b0;
      program_req = 1'b0;
      entered_code = 16'h0;
      m_code = 16'h1234;
      m_att = 3;
      m_st = M_LOCKED;
      repeat (3) tick();
      sys_reset = 1'b0;
      check_levels("reset");
      check_quiet("reset");
      tick();
      try_code(16'h1234, "correct");
      pulse_req(1, 0, "relock");
      pulse_req(0, 1, "locked_ignores_prog");
      try_code(16'h0000, "wrong1");
      try_code(16'h0000, "wrong2");
      try_code(16'h0000, "wrong3");
      wait_lockout(0, "lockout");
      tick();
      try_code(16'h1234, "open_for_prog");
      ignored_code(16'h1234, "open_ignores_code");
      pulse_req(0, 1, "enter_prog");
      prog_code(16'h12A4, "invalid_prog");
      prog_code(16'h5678, "valid_prog");
      pulse_req(0, 1, "enter_prog2");
      pulse_req(1, 0, "prog_lock");
      try_code(16'h1234, "old_code");
      try_code(16'h5678, "new_code");
      pulse_req(1, 1, "lock_wins");
      code_complete = 1'b1;
      entered_code = 16'h0001;
      tick();
      entered_code = 16'h5678;
      tick();
      code_complete = 1'b0;
      m_att = 2;
      check("dropped.fail", fail_pulse, 1);
      check_levels("dropped");
      tick();
      check_quiet("dropped.after");
      check_levels("dropped.after");
      try_code(16'h0000, "rst_w1");
      try_code(16'h0000, "rst_w2");
      repeat (4) tick();
      sys_reset = 1'b1;
      tick();
      sys_reset = 1'b0;
      m_st = M_LOCKED;
      m_att = 3;
      m_code = 16'h1234;
      check_levels("mid_lockout_reset");
      tick();
      try_code(16'h1234, "default_restored");
      pulse_req(1, 0, "relock2");
      for (int i = 0; i < 3; i++) try_code(16'h4321, "pre_master");
      repeat (2) tick();
      code_complete = 1'b1;
      entered_code = 16'h9999;
      tick();
      code_complete = 1'b0;
      if (MASTER_EN) begin
         m_st = M_OPEN;
         m_att = 3;
         check("master.success", success_pulse, 1);
         check("master.clear", entry_clear, 1);
         check_levels("master");
         pulse_req(1, 0, "master_relock");
      end else wait_lockout(3, "master_ignored");
      for (int i = 0; i < 60; i++) begin
         int r = int'($urandom_range(0, 3));
         case (m_st)
            M_LOCKED: if (r == 0) try_code(m_code, "rnd_good");
               else if (r == 3) pulse_req(1'($urandom), 1'($urandom), "rnd_locked_req");
               else try_code(rand_bcd(), "rnd_code");
            M_OPEN: if (r == 3) ignored_code(rand_bcd(), "rnd_open_code");
               else pulse_req(r != 1, r != 0, "rnd_open_req");
            M_PROG: if (r == 0) pulse_req(1, 0, "rnd_prog_lock");
               else if (r == 2) begin
                  bad = rand_bcd();
                  bad[$urandom_range(0, 3) * 4 +: 4] = 4'($urandom_range(10, 15));
                  prog_code(bad, "rnd_prog_bad");
               end else prog_code(rand_bcd(), "rnd_prog_good");
            default: wait_lockout(0, "rnd_lockout");
         endcase
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
